// File: rtl/paddle_encoder_ctrl.sv
// paddle_encoder_ctrl: quadrature-encoder paddle controller.
// The a, b and autopilot inputs are synchronized. The encoder channels are also debounced.
// Accepted encoder transitions move the paddle in manual mode.
// In autopilot mode the paddle tracks the ball by one line per frame.
module paddle_encoder_ctrl #(
  parameter int SHEIGHT         = 480,
  parameter int PADDLE_HEIGHT   = 25,
  parameter int PADDLE_SPEED    = 8,
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        a,
  input  logic        b,
  input  logic        autopilot,
  input  logic [10:0] ball_y,
  input  logic        frame_tick,
  output logic [10:0] paddle_y,
  output logic        step_up,
  output logic        step_down,
  output logic        err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]     CntLast = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [12:0] PMin   = 13'(PADDLE_HEIGHT);
  localparam logic signed [12:0] PMax   = 13'(SHEIGHT - 1 - PADDLE_HEIGHT);
  localparam logic signed [12:0] Speed  = 13'(PADDLE_SPEED);
  localparam logic [10:0]        PReset = 11'(SHEIGHT / 2);

  // Synchronizer stages, bit order {autopilot, a, b}
  logic [2:0]         r_sync1, r_sync2;
  logic [1:0][CW-1:0] r_cnt;
  logic [1:0]         r_acc, r_prev;   // accepted {a, b} and its one-cycle-old copy
  logic [10:0]        r_paddle_y;
  logic               r_step_up, r_step_down, r_err;

  logic               w_ap;
  logic [1:0]         w_enc;
  logic [1:0]         w_cur_idx, w_prev_idx, w_diff;
  logic               w_up, w_down, w_bad;
  logic signed [12:0] w_delta, w_sum;
  logic [10:0]        w_paddle_next;

  assign w_ap  = r_sync2[2];
  assign w_enc = r_sync2[1:0];

  // Two-flop synchronizers for every asynchronous input
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {autopilot, a, b};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a level once it has differed for DEBOUNCE_CYCLES synced cycles
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_enc[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_acc[i] <= w_enc[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Map Gray code 00,10,11,01 to 0..3 so one step down is +1 modulo 4
  always_comb begin
    w_cur_idx  = {r_acc[0], r_acc[1] ^ r_acc[0]};
    w_prev_idx = {r_prev[0], r_prev[1] ^ r_prev[0]};
    w_diff     = w_cur_idx - w_prev_idx;
    w_down     = (w_diff == 2'd1);
    w_up       = (w_diff == 2'd3);
    w_bad      = (w_diff == 2'd2);
  end

  // Next paddle position, computed signed and wide so a decrement never wraps before clamping
  always_comb begin
    w_delta = '0;
    if (w_ap) begin
      if (frame_tick) begin
        if (ball_y > r_paddle_y)      w_delta = 13'sd1;
        else if (ball_y < r_paddle_y) w_delta = -13'sd1;
      end
    end else if (w_down) begin
      w_delta = Speed;
    end else if (w_up) begin
      w_delta = -Speed;
    end
    w_sum = $signed({2'b00, r_paddle_y}) + w_delta;
    if (w_sum < PMin)      w_paddle_next = 11'(PMin);
    else if (w_sum > PMax) w_paddle_next = 11'(PMax);
    else                   w_paddle_next = 11'(w_sum);
  end

  // Registered decoder history, position and pulses
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev      <= '0;
      r_paddle_y  <= PReset;
      r_step_up   <= 1'b0;
      r_step_down <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prev      <= r_acc;
      r_paddle_y  <= w_paddle_next;
      r_step_up   <= w_up;
      r_step_down <= w_down;
      r_err       <= w_bad;
    end
  end

  assign paddle_y  = r_paddle_y;
  assign step_up   = r_step_up;
  assign step_down = r_step_down;
  assign err       = r_err;

endmodule

// File: tb/tb_paddle_encoder_ctrl.sv
// Scoreboard bench for paddle_encoder_ctrl with a short debounce window.
module tb_paddle_encoder_ctrl;
  localparam int D      = 4;
  localparam int PMIN   = 25;
  localparam int PMAX   = 454;
  localparam int PSPEED = 8;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a = 1'b0, b = 1'b0, autopilot = 1'b0, frame_tick = 1'b0;
  logic [10:0] ball_y = '0;
  logic [10:0] paddle_y;
  logic        step_up, step_down, err;

  paddle_encoder_ctrl #(
    .SHEIGHT(480), .PADDLE_HEIGHT(25), .PADDLE_SPEED(8), .DEBOUNCE_CYCLES(D)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .a(a), .b(b), .autopilot(autopilot),
    .ball_y(ball_y), .frame_tick(frame_tick), .paddle_y(paddle_y),
    .step_up(step_up), .step_down(step_down), .err(err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int cyc;
    bit up;
    bit dn;
    bit er;
    int y;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  int   model_y = 240;
  int   pos = 0;       // encoder position 0..3 along the down sequence
  bit   ap_model = 1'b0;
  bit [1:0] codes [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: compare DUT outputs against queued expectations
  always @(negedge pclk) begin
    exp_t e;
    if (!reset_n) begin
      vectors++;
      if (paddle_y !== 11'd240 || step_up !== 1'b0 || step_down !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: got y=%0d up=%b dn=%b err=%b, want y=240 up=0 dn=0 err=0",
                 paddle_y, step_up, step_down, err);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL missed_event: expected at cycle %0d, now cycle %0d", e.cyc, cyc);
      end else if (paddle_y !== 11'(e.y) || step_up !== e.up || step_down !== e.dn ||
                   err !== e.er) begin
        fails++;
        $display("FAIL event@%0d: got y=%0d up=%b dn=%b err=%b, want y=%0d up=%b dn=%b err=%b",
                 cyc, paddle_y, step_up, step_down, err, e.y, e.up, e.dn, e.er);
      end
    end else if (step_up || step_down || err) begin
      vectors++;
      fails++;
      $display("FAIL unexpected_pulse@%0d: got up=%b dn=%b err=%b, want none",
               cyc, step_up, step_down, err);
    end
  end

  function automatic int clampy(int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  task automatic push(int at, bit up, bit dn, bit er);
    exp_t e;
    e.cyc = at;
    e.up  = up;
    e.dn  = dn;
    e.er  = er;
    e.y   = model_y;
    q.push_back(e);
  endtask

  // Move the encoder k positions: 1 = down step, 3 = up step, 2 = illegal jump
  task automatic enc_move(int k);
    pos = (pos + k) % 4;
    {a, b} = codes[pos];
    if (!ap_model && k == 1) model_y = clampy(model_y + PSPEED);
    if (!ap_model && k == 3) model_y = clampy(model_y - PSPEED);
    push(cyc + D + 3, k == 3, k == 1, k == 2);
    repeat (D + 6) @(negedge pclk);
  endtask

  // Pulse one channel for fewer synced cycles than the debounce window
  task automatic glitch();
    int len = $urandom_range(1, D - 1);
    bit ch  = 1'($urandom_range(0, 1));
    if (ch) a = ~a; else b = ~b;
    repeat (len) @(negedge pclk);
    if (ch) a = ~a; else b = ~b;
    repeat (D + 4) @(negedge pclk);
  endtask

  task automatic ftick();
    frame_tick = 1'b1;
    if (ap_model) begin
      if (int'(ball_y) > model_y)      model_y = clampy(model_y + 1);
      else if (int'(ball_y) < model_y) model_y = clampy(model_y - 1);
    end
    push(cyc + 1, 1'b0, 1'b0, 1'b0);
    @(negedge pclk);
    frame_tick = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  // Reset with the encoder held at raw; after release the level is decoded against 00
  task automatic do_reset(bit [1:0] raw);
    int np = 0;
    int k;
    @(posedge pclk);
    #2;
    reset_n   = 1'b0;
    {a, b}    = raw;
    autopilot = 1'b0;
    ap_model  = 1'b0;
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    model_y = 240;
    for (int p = 0; p < 4; p++) if (codes[p] == raw) np = p;
    k   = np;
    pos = np;
    if (k == 1) model_y = clampy(model_y + PSPEED);
    if (k == 3) model_y = clampy(model_y - PSPEED);
    if (k != 0) push(cyc + D + 3, k == 3, k == 1, k == 2);
    repeat (D + 6) @(negedge pclk);
  endtask

  initial begin
    // a held high through reset: one down step D+3 edges after release
    do_reset(2'b10);
    // Complete the down sequence to 272
    repeat (3) enc_move(1);
    // Short glitches are rejected
    repeat (3) glitch();
    // Both channels together: illegal transition
    enc_move(2);
    // Clamp at the top and the bottom
    repeat (30) enc_move(3);
    repeat (60) enc_move(1);
    repeat (5) enc_move(3);
    // Reset in the middle of a pending step
    a = ~a;
    repeat (2) @(negedge pclk);
    do_reset(2'b11);
    // Random mix of steps, illegal jumps, glitches and ignored frame ticks
    for (int i = 0; i < 120; i++) begin
      int r = $urandom_range(0, 9);
      if (r <= 5)      enc_move($urandom_range(0, 1) ? 1 : 3);
      else if (r == 6) enc_move(2);
      else if (r <= 8) glitch();
      else             ftick();
    end
    // Autopilot: ball above paddle, five ticks walk it up by 5; steps still pulse
    do_reset(2'b00);
    autopilot = 1'b1;
    repeat (4) @(negedge pclk);
    ap_model = 1'b1;
    ball_y   = 11'd100;
    repeat (5) ftick();
    repeat (6) enc_move($urandom_range(0, 1) ? 1 : 3);
    for (int i = 0; i < 4; i++) begin
      ball_y = 11'($urandom_range(0, 700));
      repeat (8) ftick();
      if (i == 1) enc_move(2);
    end
    // Back to manual: frame ticks ignored, steps move again
    autopilot = 1'b0;
    repeat (4) @(negedge pclk);
    ap_model = 1'b0;
    repeat (3) ftick();
    repeat (4) enc_move($urandom_range(0, 1) ? 1 : 3);

    repeat (20) @(negedge pclk);
    while (q.size() > 0) begin
      exp_t e = q.pop_front();
      vectors++;
      fails++;
      $display("FAIL never_checked: event for cycle %0d still queued, want none", e.cyc);
    end
    vectors++;
    if (paddle_y !== 11'(model_y)) begin
      fails++;
      $display("FAIL final_position: got %0d, want %0d", paddle_y, model_y);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
